// File: rtl/hawk_axi_rd_arb.sv
// hawk_axi_rd_arb: shares one AXI4 read port (AR + R) among NUM_REQ requesters.
// AR requests use round-robin arbitration. A requester can hold a lock so that
// a sequence of its requests is issued back-to-back. R beats come back in order.
// They are routed to the right requester through an order FIFO that holds the
// index of each granted requester.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that edge. A sink may assert ready at any time. Ready may depend
// combinationally on valid; valid never depends on ready.
module hawk_axi_rd_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int RESP_W     = 2,
  parameter int MAX_OUTSTD = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_araddr_i,
  input  logic [NUM_REQ*8-1:0]           req_arlen_i,
  input  logic [NUM_REQ-1:0]             req_lock_i,
  output logic [NUM_REQ-1:0]             req_arready_o,
  output logic [NUM_REQ-1:0]             req_rvalid_o,
  input  logic [NUM_REQ-1:0]             req_rready_i,
  output logic [DATA_W-1:0]              rdata_o,
  output logic [RESP_W-1:0]              rresp_o,
  output logic                           rlast_o,
  output logic                           m_arvalid_o,
  output logic [ADDR_W-1:0]              m_araddr_o,
  output logic [7:0]                     m_arlen_o,
  input  logic                           m_arready_i,
  input  logic                           m_rvalid_i,
  input  logic [DATA_W-1:0]              m_rdata_i,
  input  logic [RESP_W-1:0]              m_rresp_i,
  input  logic                           m_rlast_i,
  output logic                           m_rready_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [$clog2(MAX_OUTSTD+1)-1:0] outstd_cnt_o,
  output logic                           err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTD + 1);

  // AR output stage
  logic              m_arvalid_q, m_arvalid_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [7:0]        m_arlen_q, m_arlen_d;

  // Arbitration state
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic [IDX_W-1:0]  owner_q, owner_d;

  // Order FIFO of granted requester indices
  logic [IDX_W-1:0]  fifo_mem_q [MAX_OUTSTD];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // Combinational helpers
  logic              stage_free;
  logic              can_issue;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W:0]    cand;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_len;
  logic              fifo_empty;
  logic [IDX_W-1:0]  head;
  logic              pop;

  // The AR stage can take a new request when it is empty or is being drained
  // this cycle. Occupancy is checked on the registered count. A pop in the
  // same cycle therefore does not free a slot until the next cycle. Issue is
  // blocked while reset is asserted, so no request is accepted during reset.
  assign stage_free = !m_arvalid_q || m_arready_i;
  assign can_issue  = rst_ni && stage_free && (cnt_q < CNT_W'(MAX_OUTSTD));

  // Winner select: the lock owner only while locked, else round-robin from rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (lock_q) begin
      win_found = req_arvalid_i[owner_q];
      win_idx   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
        if (!win_found && req_arvalid_i[cand[IDX_W-1:0]]) begin
          win_found = 1'b1;
          win_idx   = cand[IDX_W-1:0];
        end
      end
    end
  end

  assign accept = can_issue && win_found;

  // Payload mux for the winning requester
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        sel_addr = req_araddr_i[k*ADDR_W +: ADDR_W];
        sel_len  = req_arlen_i[k*8 +: 8];
      end
    end
  end

  // Per-requester AR ready: one-hot on the accepted requester
  always_comb begin
    req_arready_o = '0;
    if (accept) req_arready_o[win_idx] = 1'b1;
  end

  // Next state for the AR stage, the round-robin pointer and the lock
  always_comb begin
    m_arvalid_d = m_arvalid_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    if (m_arvalid_q && m_arready_i) m_arvalid_d = 1'b0;
    if (accept) begin
      m_arvalid_d = 1'b1;
      m_araddr_d  = sel_addr;
      m_arlen_d   = sel_len;
      rr_ptr_d    = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      lock_d      = req_lock_i[win_idx];
      owner_d     = win_idx;
    end else if (lock_q && !req_lock_i[owner_q]) begin
      // The owner can release the lock without issuing another request
      lock_d = 1'b0;
    end
  end

  // R routing: beats go to the FIFO head. With nothing outstanding, beats are
  // drained and flagged as an error.
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    req_rvalid_o = '0;
    m_rready_o   = 1'b1;
    if (!fifo_empty) begin
      req_rvalid_o[head] = m_rvalid_i;
      m_rready_o         = req_rready_i[head];
    end
  end

  assign pop     = !fifo_empty && m_rvalid_i && m_rready_o && m_rlast_i;
  assign rdata_o = m_rdata_i;
  assign rresp_o = m_rresp_i;
  assign rlast_o = m_rlast_i;

  // Order FIFO pointer, occupancy and error next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (accept) wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTD-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTD-1)) ? '0 : rd_ptr_q + 1'b1;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
    if (m_rvalid_i && fifo_empty) err_d = 1'b1;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      owner_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage: an entry is only read while it is valid, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem_q[wr_ptr_q] <= win_idx;
  end

  assign m_arvalid_o  = m_arvalid_q;
  assign m_araddr_o   = m_araddr_q;
  assign m_arlen_o    = m_arlen_q;
  assign outstd_cnt_o = cnt_q;
  assign err_o        = err_q;
  assign grant_o      = lock_q ? (NUM_REQ'(1) << owner_q) : '0;

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// Directed testbench for hawk_axi_rd_arb. Inputs change 1 ns after a rising
// edge. Combinational outputs are sampled 1 ns later. Registered outputs are
// sampled right after the edge that loads them.
module tb_hawk_axi_rd_arb;

  localparam int NUM_REQ    = 4;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 512;
  localparam int RESP_W     = 2;
  localparam int MAX_OUTSTD = 8;
  localparam int CNT_W      = $clog2(MAX_OUTSTD + 1);

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_arvalid;
  logic [NUM_REQ*ADDR_W-1:0] req_araddr;
  logic [NUM_REQ*8-1:0]      req_arlen;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_arready;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [NUM_REQ-1:0]        req_rready;
  logic [DATA_W-1:0]         rdata;
  logic [RESP_W-1:0]         rresp;
  logic                      rlast;
  logic                      m_arvalid;
  logic [ADDR_W-1:0]         m_araddr;
  logic [7:0]                m_arlen;
  logic                      m_arready;
  logic                      m_rvalid;
  logic [DATA_W-1:0]         m_rdata;
  logic [RESP_W-1:0]         m_rresp;
  logic                      m_rlast;
  logic                      m_rready;
  logic [NUM_REQ-1:0]        grant;
  logic [CNT_W-1:0]          outstd_cnt;
  logic                      err;

  int n_checks = 0;
  int n_pass   = 0;

  hawk_axi_rd_arb #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RESP_W(RESP_W), .MAX_OUTSTD(MAX_OUTSTD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_arvalid_i(req_arvalid), .req_araddr_i(req_araddr), .req_arlen_i(req_arlen),
    .req_lock_i(req_lock), .req_arready_o(req_arready), .req_rvalid_o(req_rvalid),
    .req_rready_i(req_rready), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .m_arvalid_o(m_arvalid), .m_araddr_o(m_araddr), .m_arlen_o(m_arlen),
    .m_arready_i(m_arready), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
    .m_rresp_i(m_rresp), .m_rlast_i(m_rlast), .m_rready_o(m_rready),
    .grant_o(grant), .outstd_cnt_o(outstd_cnt), .err_o(err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_lock = '0;
    req_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    m_rresp = '0; m_rlast = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    req_araddr[i*ADDR_W +: ADDR_W] = a;
    req_arlen[i*8 +: 8] = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req_arvalid = '1; m_arready = 1'b1; req_rready = '1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m_arvalid !== 1'b0) $display("FAIL reset_arvalid got %0h exp 0", m_arvalid); else n_pass++;
    n_checks++; if (m_araddr !== '0) $display("FAIL reset_araddr got %0h exp 0", m_araddr); else n_pass++;
    n_checks++; if (m_arlen !== 8'd0) $display("FAIL reset_arlen got %0h exp 0", m_arlen); else n_pass++;
    n_checks++; if (req_arready !== 4'b0000) $display("FAIL reset_arready got %0b exp 0000", req_arready); else n_pass++;
    n_checks++; if (req_rvalid !== 4'b0000) $display("FAIL reset_rvalid got %0b exp 0000", req_rvalid); else n_pass++;
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant got %0b exp 0000", grant); else n_pass++;
    n_checks++; if (outstd_cnt !== '0) $display("FAIL reset_cnt got %0d exp 0", outstd_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %0b exp 0", err); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (m_arvalid !== 1'b0) $display("FAIL reset_no_accept got %0b exp 0", m_arvalid); else n_pass++;
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_rr();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 64'h1000 + 64'(i) * 64'h10, 8'(i));
    req_arvalid = 4'hF; m_arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_rdy = 4'b0001 << c;
      n_checks++; if (req_arready !== exp_rdy) $display("FAIL rr_arready[%0d] got %0b exp %0b", c, req_arready, exp_rdy); else n_pass++;
      step();
      req_arvalid[c] = 1'b0;
      n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 64'h1000 + 64'(c) * 64'h10)
        $display("FAIL rr_araddr[%0d] got %0h/%0h exp 1/%0h", c, m_arvalid, m_araddr, 64'h1000 + 64'(c) * 64'h10); else n_pass++;
      n_checks++; if (m_arlen !== 8'(c)) $display("FAIL rr_arlen[%0d] got %0d exp %0d", c, m_arlen, c); else n_pass++;
    end
    #1;
    n_checks++; if (req_arready !== 4'b0000) $display("FAIL rr_idle got %0b exp 0000", req_arready); else n_pass++;
    n_checks++; if (outstd_cnt !== CNT_W'(4)) $display("FAIL rr_cnt got %0d exp 4", outstd_cnt); else n_pass++;
  endtask

  task automatic test_lock();
    do_reset();
    m_arready = 1'b1;
    set_req(0, 64'h3000, 8'd0);
    set_req(1, 64'h2000, 8'd0);
    set_req(2, 64'h4000, 8'd0);
    req_arvalid = 4'b0010; req_lock = 4'b0010;
    #1;
    n_checks++; if (req_arready !== 4'b0010) $display("FAIL lock_first got %0b exp 0010", req_arready); else n_pass++;
    step();
    req_arvalid = 4'b0111;
    n_checks++; if (grant !== 4'b0010) $display("FAIL lock_grant got %0b exp 0010", grant); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      req_lock[1] = (k < 3);
      #1;
      n_checks++; if (req_arready !== 4'b0010) $display("FAIL lock_hold[%0d] got %0b exp 0010", k, req_arready); else n_pass++;
      step();
    end
    req_arvalid = 4'b0101;
    #1;
    n_checks++; if (grant !== 4'b0000) $display("FAIL lock_release got %0b exp 0000", grant); else n_pass++;
    n_checks++; if (req_arready !== 4'b0100) $display("FAIL lock_next got %0b exp 0100", req_arready); else n_pass++;
    step();
    n_checks++; if (m_araddr !== 64'h4000) $display("FAIL lock_next_addr got %0h exp 4000", m_araddr); else n_pass++;
    req_arvalid = 4'b0001;
    #1;
    n_checks++; if (req_arready !== 4'b0001) $display("FAIL lock_then_req0 got %0b exp 0001", req_arready); else n_pass++;
    step();
    req_arvalid = '0;
  endtask

  task automatic test_routing();
    logic [DATA_W-1:0] d;
    do_reset();
    m_arready = 1'b1; req_rready = 4'hF;
    set_req(2, 64'h5000, 8'd0);
    set_req(0, 64'h6000, 8'd3);
    req_arvalid = 4'b0100;
    #1;
    n_checks++; if (req_arready !== 4'b0100) $display("FAIL route_ar2 got %0b exp 0100", req_arready); else n_pass++;
    step();
    req_arvalid = 4'b0001;
    #1;
    n_checks++; if (req_arready !== 4'b0001) $display("FAIL route_ar0 got %0b exp 0001", req_arready); else n_pass++;
    step();
    req_arvalid = '0;
    n_checks++; if (m_arlen !== 8'd3) $display("FAIL route_arlen got %0d exp 3", m_arlen); else n_pass++;
    d = '0; d[31:0] = 32'hA5A5_0001;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = d; m_rresp = 2'b01;
    #1;
    n_checks++; if (req_rvalid !== 4'b0100) $display("FAIL route_beat_r2 got %0b exp 0100", req_rvalid); else n_pass++;
    n_checks++; if (rdata !== d || rresp !== 2'b01 || rlast !== 1'b1) $display("FAIL route_passthru got %0h/%0h exp %0h/1", rdata[31:0], rresp, d[31:0]); else n_pass++;
    n_checks++; if (m_rready !== 1'b1) $display("FAIL route_rready got %0b exp 1", m_rready); else n_pass++;
    step();
    for (int b = 0; b < 4; b++) begin
      m_rlast = (b == 3); m_rdata = DATA_W'(b + 16); m_rresp = 2'b00;
      #1;
      n_checks++; if (req_rvalid !== 4'b0001) $display("FAIL route_beat_r0[%0d] got %0b exp 0001", b, req_rvalid); else n_pass++;
      step();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    n_checks++; if (outstd_cnt !== '0) $display("FAIL route_cnt got %0d exp 0", outstd_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL route_err got %0b exp 0", err); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    m_arready = 1'b1; req_rready = 4'hF;
    set_req(3, 64'h7000, 8'd0);
    req_arvalid = 4'b1000;
    for (int k = 0; k < MAX_OUTSTD; k++) begin
      #1;
      n_checks++; if (req_arready !== 4'b1000) $display("FAIL full_fill[%0d] got %0b exp 1000", k, req_arready); else n_pass++;
      step();
    end
    n_checks++; if (outstd_cnt !== CNT_W'(MAX_OUTSTD)) $display("FAIL full_cnt got %0d exp %0d", outstd_cnt, MAX_OUTSTD); else n_pass++;
    #1;
    n_checks++; if (req_arready !== 4'b0000) $display("FAIL full_block got %0b exp 0000", req_arready); else n_pass++;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    n_checks++; if (req_arready !== 4'b0000) $display("FAIL full_pop_same_cycle got %0b exp 0000", req_arready); else n_pass++;
    n_checks++; if (req_rvalid !== 4'b1000) $display("FAIL full_rvalid got %0b exp 1000", req_rvalid); else n_pass++;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    n_checks++; if (outstd_cnt !== CNT_W'(MAX_OUTSTD - 1)) $display("FAIL full_after_pop got %0d exp %0d", outstd_cnt, MAX_OUTSTD - 1); else n_pass++;
    #1;
    n_checks++; if (req_arready !== 4'b1000) $display("FAIL full_ninth got %0b exp 1000", req_arready); else n_pass++;
    step();
    req_arvalid = '0;
    n_checks++; if (outstd_cnt !== CNT_W'(MAX_OUTSTD)) $display("FAIL full_refill got %0d exp %0d", outstd_cnt, MAX_OUTSTD); else n_pass++;
  endtask

  task automatic test_err_backpressure();
    do_reset();
    m_rvalid = 1'b1; m_rlast = 1'b1; req_rready = '0;
    #1;
    n_checks++; if (m_rready !== 1'b1) $display("FAIL err_drain_rready got %0b exp 1", m_rready); else n_pass++;
    n_checks++; if (req_rvalid !== 4'b0000) $display("FAIL err_drain_rvalid got %0b exp 0000", req_rvalid); else n_pass++;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    n_checks++; if (err !== 1'b1) $display("FAIL err_set got %0b exp 1", err); else n_pass++;
    step();
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %0b exp 1", err); else n_pass++;
    set_req(0, 64'h8000, 8'd0);
    set_req(1, 64'h9000, 8'd0);
    req_arvalid = 4'b0001; m_arready = 1'b0;
    #1;
    n_checks++; if (req_arready !== 4'b0001) $display("FAIL bp_ar0 got %0b exp 0001", req_arready); else n_pass++;
    step();
    req_arvalid = 4'b0010;
    #1;
    n_checks++; if (req_arready !== 4'b0000) $display("FAIL bp_stage_busy got %0b exp 0000", req_arready); else n_pass++;
    step();
    n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 64'h8000) $display("FAIL bp_ar_hold got %0b/%0h exp 1/8000", m_arvalid, m_araddr); else n_pass++;
    m_arready = 1'b1;
    #1;
    n_checks++; if (req_arready !== 4'b0010) $display("FAIL bp_stage_free got %0b exp 0010", req_arready); else n_pass++;
    step();
    req_arvalid = '0;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    n_checks++; if (m_rready !== 1'b0) $display("FAIL bp_rready_stall got %0b exp 0", m_rready); else n_pass++;
    n_checks++; if (req_rvalid !== 4'b0001) $display("FAIL bp_rvalid_head got %0b exp 0001", req_rvalid); else n_pass++;
    step();
    n_checks++; if (outstd_cnt !== CNT_W'(2)) $display("FAIL bp_cnt_stalled got %0d exp 2", outstd_cnt); else n_pass++;
    req_rready = 4'b0001;
    #1;
    n_checks++; if (m_rready !== 1'b1) $display("FAIL bp_rready_go got %0b exp 1", m_rready); else n_pass++;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    n_checks++; if (outstd_cnt !== CNT_W'(1)) $display("FAIL bp_cnt_pop got %0d exp 1", outstd_cnt); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL err_still_set got %0b exp 1", err); else n_pass++;
  endtask

  // Sequence of scenarios and final report
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_rr();
    test_lock();
    test_routing();
    test_full();
    test_err_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
